// File: rtl/storage_pkg.sv
// storage_pkg: slot encoding, slot-to-select mapping and loader FSM states for the register-store loader
package storage_pkg;
  localparam logic [1:0] SLOT_A = 2'd0;
  localparam logic [1:0] SLOT_B = 2'd1;
  localparam logic [1:0] SLOT_C = 2'd2;
  localparam logic [1:0] SLOT_D = 2'd3;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} load_state_e;
  // {SEL_AB,SEL_A}: A=11, B=10, C=01, D=00, which is the bitwise inverse of the slot index
  function automatic logic [1:0] slot_sel(input logic [1:0] slot);
    return ~slot;
  endfunction
endpackage

// File: rtl/storage_loader.sv
// storage_loader: sequences valid/ready words into a four-slot store with setup/strobe/hold write timing
//   CLK, RST (async active-low)             clock and reset
//   IN_DATA, IN_VALID, IN_READY             word handshake
//   IN_DIRECT, IN_ADDR                      explicit slot select instead of the auto pointer
//   CLEAR                                   return the auto pointer to slot A
//   WRITE_ENB, SEL_AB, SEL_A, DATA          store write interface (all registered)
//   PTR, DONE                               auto pointer and end-of-fill pulse
module storage_loader
  import storage_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STROBE_LEN = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] IN_DATA,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             IN_DIRECT,
  input  logic [1:0]       IN_ADDR,
  input  logic             CLEAR,
  output logic             WRITE_ENB,
  output logic             SEL_AB,
  output logic             SEL_A,
  output logic [WIDTH-1:0] DATA,
  output logic [1:0]       PTR,
  output logic             DONE
);
  localparam int CW = $clog2(STROBE_LEN + 1);
  load_state_e      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d, sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             we_q, we_d, done_q, done_d, auto_q, auto_d;
  assign IN_READY  = RST && (state_q == IDLE) && !CLEAR;
  assign WRITE_ENB = we_q;
  assign {SEL_AB, SEL_A} = sel_q;
  assign DATA      = data_q;
  assign PTR       = ptr_q;
  assign DONE      = done_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    auto_d  = auto_q;
    case (state_q)
      IDLE: if (IN_VALID && IN_READY) begin
        state_d = SETUP;
        data_d  = IN_DATA;
        sel_d   = slot_sel(IN_DIRECT ? IN_ADDR : ptr_q);
        auto_d  = !IN_DIRECT;
      end
      SETUP: begin
        state_d = STROBE;
        we_d    = 1'b1;
        cnt_d   = CW'(STROBE_LEN - 1);
      end
      STROBE: if (cnt_q == '0) state_d = HOLD;
      else begin
        we_d  = 1'b1;
        cnt_d = cnt_q - 1'b1;
      end
      HOLD: begin
        state_d = IDLE;
        if (auto_q) begin
          ptr_d  = ptr_q + 1'b1;
          done_d = (sel_q == slot_sel(SLOT_D));
        end
      end
      default: state_d = IDLE;
    endcase
    // A CLEAR seen while a write is in flight cancels that write's pointer advance and DONE
    if (CLEAR) begin
      ptr_d  = '0;
      done_d = 1'b0;
      auto_d = 1'b0;
    end
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= SLOT_A;
      sel_q   <= slot_sel(SLOT_A);
      data_q  <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      auto_q  <= auto_d;
    end
  end
endmodule

// File: tb/tb_storage_loader.sv
// tb_storage_loader: scoreboard bench for storage_loader (STROBE_LEN=1 and STROBE_LEN=3 instances)
module tb_storage_loader;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;
  logic [7:0] in_data, data;
  logic       in_valid, in_ready, in_direct, clear, we, sel_ab, sel_a, done;
  logic [1:0] in_addr, ptr;
  logic [7:0] b_in_data, b_data;
  logic       b_valid, b_ready, b_we, b_sel_ab, b_sel_a, b_done;
  logic [1:0] b_ptr;
  storage_loader #(.WIDTH(8), .STROBE_LEN(1)) u_dut (
    .CLK(CLK), .RST(RST), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .IN_DIRECT(in_direct), .IN_ADDR(in_addr), .CLEAR(clear), .WRITE_ENB(we),
    .SEL_AB(sel_ab), .SEL_A(sel_a), .DATA(data), .PTR(ptr), .DONE(done));
  storage_loader #(.WIDTH(8), .STROBE_LEN(3)) u_dut3 (
    .CLK(CLK), .RST(RST), .IN_DATA(b_in_data), .IN_VALID(b_valid), .IN_READY(b_ready),
    .IN_DIRECT(1'b0), .IN_ADDR(2'd0), .CLEAR(1'b0), .WRITE_ENB(b_we),
    .SEL_AB(b_sel_ab), .SEL_A(b_sel_a), .DATA(b_data), .PTR(b_ptr), .DONE(b_done));
  int checks = 0;
  int errors = 0;
  logic [10:0] exp_q[$];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic wait_idle();
    int n = 0;
    @(negedge CLK);
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) chk("wait_idle_timeout", in_ready, 1);
  endtask
  task automatic send(input logic [7:0] d, input logic dir, input logic [1:0] addr,
                      input logic [1:0] esel, input logic edone);
    int n = 0;
    @(negedge CLK);
    in_data = d; in_direct = dir; in_addr = addr; in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge CLK);
      n++;
    end
    if (!in_ready) chk("send_timeout", in_ready, 1);
    exp_q.push_back({edone, esel, d});
    @(posedge CLK);
    #1 in_valid = 1'b0;
  endtask
  initial begin
    logic        prev_we = 1'b0, pend = 1'b0;
    logic [7:0]  prev_data = '0;
    logic [1:0]  prev_sel = '0;
    logic [10:0] cur = '0;
    int          len = 0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        prev_we = 1'b0;
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("done_after_hold", done, cur[10]);
          pend = 1'b0;
        end else if (done) begin
          checks++; errors++;
          $display("FAIL spurious_done: got 1 expected 0");
        end
        if (we && !prev_we) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_strobe: got strobe sel=%b data=%0h expected none", {sel_ab, sel_a}, data);
          end else begin
            cur = exp_q.pop_front();
            chk("strobe_sel", {sel_ab, sel_a}, cur[9:8]);
            chk("strobe_data", data, cur[7:0]);
            chk("setup_sel", prev_sel, cur[9:8]);
            chk("setup_data", prev_data, cur[7:0]);
          end
          len = 0;
        end
        if (we) len++;
        if (!we && prev_we) begin
          chk("strobe_len", len, 1);
          chk("hold_sel", {sel_ab, sel_a}, cur[9:8]);
          chk("hold_data", data, cur[7:0]);
          pend = 1'b1;
        end
        prev_we = we; prev_data = data; prev_sel = {sel_ab, sel_a};
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [1:0] sel_tab [4];
    logic       we_tab [6];
    logic       rdy_tab [6];
    int         acc;
    sel_tab = '{2'b11, 2'b10, 2'b01, 2'b00};
    we_tab  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    rdy_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    in_data = '0; in_valid = 0; in_direct = 0; in_addr = '0; clear = 0;
    b_in_data = '0; b_valid = 0;
    repeat (2) @(negedge CLK);
    chk("rst_we", we, 0);
    chk("rst_ptr", ptr, 0);
    chk("rst_sel", {sel_ab, sel_a}, 2'b11);
    chk("rst_data", data, 0);
    chk("rst_done", done, 0);
    chk("rst_ready_forced_low", in_ready, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("ready_after_reset", in_ready, 1);
    send(8'h11, 0, 2'd0, 2'b11, 0);
    send(8'h22, 0, 2'd0, 2'b10, 0);
    send(8'h33, 0, 2'd0, 2'b01, 0);
    send(8'h44, 0, 2'd0, 2'b00, 1);
    wait_idle();
    chk("fill_ptr_wrap", ptr, 0);
    send(8'h55, 0, 2'd0, 2'b11, 0);
    send(8'hA5, 1, 2'd3, 2'b00, 0);
    wait_idle();
    chk("direct_ptr_kept", ptr, 1);
    send(8'h66, 0, 2'd0, 2'b10, 0);
    send(8'h77, 0, 2'd0, 2'b01, 0);
    wait_idle();
    chk("ptr_at_d", ptr, 3);
    send(8'h88, 0, 2'd0, 2'b00, 0);
    @(posedge CLK);
    @(negedge CLK);
    chk("clear_race_we", we, 1);
    clear = 1'b1;
    @(posedge CLK);
    #1 clear = 1'b0;
    wait_idle();
    chk("clear_race_ptr", ptr, 0);
    @(negedge CLK);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h99; in_direct = 0;
    #1 chk("ready_with_clear", in_ready, 0);
    @(posedge CLK);
    #1 clear = 1'b0; in_valid = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("no_accept_with_clear", we, 0);
    end
    chk("clear_idle_ready", in_ready, 1);
    chk("clear_idle_ptr", ptr, 0);
    acc = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      in_data = 8'hB0 + 8'(i); in_valid = 1'b1; in_direct = 0;
      #1 if (in_ready && acc < 4) begin
        exp_q.push_back({acc == 3, sel_tab[acc], in_data});
        acc++;
      end
    end
    in_valid = 1'b0;
    chk("bp_accepts", acc, 4);
    wait_idle();
    chk("bp_ptr", ptr, 0);
    send(8'hC3, 0, 2'd0, 2'b11, 0);
    @(posedge CLK);
    @(negedge CLK);
    chk("pre_reset_we", we, 1);
    #2 RST = 1'b0;
    #1;
    chk("async_rst_we", we, 0);
    chk("async_rst_ptr", ptr, 0);
    chk("async_rst_sel", {sel_ab, sel_a}, 2'b11);
    chk("async_rst_data", data, 0);
    chk("async_rst_ready", in_ready, 0);
    @(negedge CLK);
    #2 RST = 1'b1;
    @(negedge CLK);
    chk("ready_after_rst_release", in_ready, 1);
    b_in_data = 8'h3C; b_valid = 1'b1;
    chk("l3_ready_before", b_ready, 1);
    @(posedge CLK);
    #1 b_valid = 1'b0;
    for (int m = 0; m < 6; m++) begin
      @(negedge CLK);
      chk($sformatf("l3_we_m%0d", m), b_we, we_tab[m]);
      chk($sformatf("l3_ready_m%0d", m), b_ready, rdy_tab[m]);
      if (m == 2) begin
        chk("l3_data", b_data, 8'h3C);
        chk("l3_sel", {b_sel_ab, b_sel_a}, 2'b11);
      end
    end
    chk("l3_ptr", b_ptr, 1);
    repeat (3) @(negedge CLK);
    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
